// File: rtl/deparser_emit_segs_if.sv
// deparser_emit_segs_if: window offer, bypass stream and output stream bundle for deparser_emit_segs
interface deparser_emit_segs_if #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS = 4
) ();
  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_1st;
  logic [2:0] segs_num;
  logic segs_has_last;
  logic [C_AXIS_DATA_WIDTH/8-1:0] segs_last_tkeep;
  logic segs_valid;
  logic segs_ready;
  logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic s_axis_tlast;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata;
  logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser;
  logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic m_axis_tready;
  logic [15:0] drop_cnt;
  modport master (
    output tdata_segs, tuser_1st, segs_num, segs_has_last, segs_last_tkeep, segs_valid,
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input segs_ready, s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tkeep,
    input m_axis_tvalid, m_axis_tlast, drop_cnt
  );
  modport slave (
    input tdata_segs, tuser_1st, segs_num, segs_has_last, segs_last_tkeep, segs_valid,
    input s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output segs_ready, s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tkeep,
    output m_axis_tvalid, m_axis_tlast, drop_cnt
  );
endinterface

// File: rtl/deparser_emit_segs.sv
// deparser_emit_segs: re-serialises a buffered header window onto AXI4-Stream, then forwards bypass payload up to tlast
module deparser_emit_segs #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS = 4
) (
  input logic axis_clk,
  input logic areset,
  deparser_emit_segs_if.slave io
);
  localparam int W = C_AXIS_DATA_WIDTH;
  localparam int KW = W / 8;
  localparam int BW = $clog2(C_NUM_SEGS);
  typedef enum logic [1:0] {IDLE, EMIT, FLUSH_REST} state_t;
  state_t state;
  logic [W-1:0] buf_beats [C_NUM_SEGS];
  logic [C_AXIS_TUSER_WIDTH-1:0] buf_tuser;
  logic [KW-1:0] buf_keep;
  logic buf_last;
  logic [BW-1:0] beat;
  logic [BW-1:0] last_beat;
  logic [2:0] num_c;
  logic emit;
  logic flush;
  logic final_beat;
  logic close;
  logic accept;
  always_comb begin
    num_c = io.segs_num < 3'd2 ? 3'd2 : io.segs_num > 3'(C_NUM_SEGS) ? 3'(C_NUM_SEGS) : io.segs_num;
    emit = state == EMIT;
    flush = state == FLUSH_REST;
    final_beat = emit && beat == last_beat;
    close = final_beat && buf_last;
    io.segs_ready = !areset && (state == IDLE || (close && io.m_axis_tready));
    accept = io.segs_valid && io.segs_ready;
    io.s_axis_tready = flush && io.m_axis_tready;
    io.m_axis_tvalid = emit || (flush && io.s_axis_tvalid);
    io.m_axis_tdata = emit ? buf_beats[beat] : flush ? io.s_axis_tdata : '0;
    io.m_axis_tuser = emit && beat == '0 ? buf_tuser : '0;
    io.m_axis_tkeep = close ? buf_keep : emit ? '1 : flush ? io.s_axis_tkeep : '0;
    io.m_axis_tlast = close || (flush && io.s_axis_tlast);
  end
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state <= IDLE;
      beat <= '0;
      last_beat <= '0;
      buf_tuser <= '0;
      buf_keep <= '0;
      buf_last <= 1'b0;
      io.drop_cnt <= '0;
      for (int k = 0; k < C_NUM_SEGS; k++) buf_beats[k] <= '0;
    end else begin
      if (io.segs_valid && !io.segs_ready && io.drop_cnt != 16'hFFFF) io.drop_cnt <= io.drop_cnt + 16'd1;
      if (accept) begin
        state <= EMIT;
        beat <= '0;
        last_beat <= BW'(num_c - 3'd1);
        buf_tuser <= io.tuser_1st;
        buf_keep <= io.segs_last_tkeep;
        buf_last <= io.segs_has_last || num_c != 3'(C_NUM_SEGS);
        for (int k = 0; k < C_NUM_SEGS; k++) buf_beats[k] <= io.tdata_segs[k*W +: W];
      end else if (emit && io.m_axis_tready) begin
        if (final_beat) state <= buf_last ? IDLE : FLUSH_REST;
        else beat <= beat + 1'b1;
      end else if (flush && io.s_axis_tvalid && io.m_axis_tready && io.s_axis_tlast) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_deparser_emit_segs.sv
// tb_deparser_emit_segs: directed windows and bypass beats checked by a queue scoreboard and output monitor
module tb_deparser_emit_segs;
  localparam int W = 256;
  localparam int TU = 128;
  localparam int N = 4;
  localparam int KW = W / 8;
  typedef struct packed {
    logic [W-1:0] d;
    logic [TU-1:0] u;
    logic [KW-1:0] k;
    logic l;
  } beat_t;
  logic clk = 1'b0;
  logic areset = 1'b1;
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  bit rand_rdy = 1'b0;
  bit held_v = 1'b0;
  beat_t held;
  beat_t q[$];
  deparser_emit_segs_if #(.C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(TU), .C_NUM_SEGS(N)) io ();
  deparser_emit_segs #(.C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(TU), .C_NUM_SEGS(N)) dut (
    .axis_clk(clk),
    .areset(areset),
    .io(io.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] mk(int p, int b);
    return {8{16'(p), 8'(b), 8'hA5}};
  endfunction
  function automatic logic [TU-1:0] mku(int p);
    return {4{32'(p) ^ 32'hC0DE0000}};
  endfunction
  task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic chk_beat(string name, beat_t got, beat_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    beat_t c;
    c = {io.m_axis_tdata, io.m_axis_tuser, io.m_axis_tkeep, io.m_axis_tlast};
    if (areset) held_v = 1'b0;
    else if (io.m_axis_tvalid) begin
      if (held_v) chk_beat("stall_hold", c, held);
      if (io.m_axis_tready) begin
        hs_cnt++;
        held_v = 1'b0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got %0h expected none", c);
        end else chk_beat("beat", c, q.pop_front());
      end else begin
        held = c;
        held_v = 1'b1;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) io.m_axis_tready = 1'($urandom_range(0, 1));
  end
  task automatic offer(int p, logic [2:0] num, bit hl, logic [KW-1:0] keep);
    int ne;
    bit he;
    int t;
    ne = num < 2 ? 2 : num > N ? N : int'(num);
    he = hl || ne != N;
    for (int k = 0; k < N; k++) io.tdata_segs[k*W +: W] = mk(p, k);
    io.tuser_1st = mku(p);
    io.segs_num = num;
    io.segs_has_last = hl;
    io.segs_last_tkeep = keep;
    for (int k = 0; k < ne; k++) begin
      beat_t e;
      e.d = mk(p, k);
      e.u = k == 0 ? mku(p) : '0;
      e.l = k == ne - 1 && he;
      e.k = e.l ? keep : '1;
      q.push_back(e);
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!io.segs_ready && t < 200);
    if (!io.segs_ready) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout got segs_ready 0 expected 1 for window %0d", p);
    end
    io.segs_valid = 1'b1;
    @(posedge clk);
    #1 io.segs_valid = 1'b0;
  endtask
  task automatic bypass(int p, int i, logic [KW-1:0] keep, bit last);
    beat_t e;
    int t;
    e.d = mk(p, 16 + i);
    e.u = '0;
    e.k = keep;
    e.l = last;
    q.push_back(e);
    io.s_axis_tdata = e.d;
    io.s_axis_tkeep = keep;
    io.s_axis_tlast = last;
    io.s_axis_tvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!io.s_axis_tready && t < 200);
    if (!io.s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL bypass_timeout got s_axis_tready 0 expected 1 for beat %0d", i);
    end
    @(posedge clk);
    #1 io.s_axis_tvalid = 1'b0;
  endtask
  task automatic pulse_drop();
    @(negedge clk);
    io.segs_valid = 1'b1;
    @(posedge clk);
    #1 io.segs_valid = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d beats left expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int h0;
    io.tdata_segs = '0;
    io.tuser_1st = '0;
    io.segs_num = '0;
    io.segs_has_last = 1'b0;
    io.segs_last_tkeep = '0;
    io.segs_valid = 1'b0;
    io.s_axis_tdata = '0;
    io.s_axis_tkeep = '0;
    io.s_axis_tlast = 1'b0;
    io.s_axis_tvalid = 1'b0;
    io.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", W'(io.m_axis_tvalid), '0);
    chk("rst_tlast", W'(io.m_axis_tlast), '0);
    chk("rst_tdata", io.m_axis_tdata, '0);
    chk("rst_tuser_tkeep", W'({io.m_axis_tuser, io.m_axis_tkeep}), '0);
    chk("rst_segs_ready", W'(io.segs_ready), '0);
    chk("rst_s_tready", W'(io.s_axis_tready), '0);
    chk("rst_drop_cnt", W'(io.drop_cnt), '0);
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("rel_segs_ready", W'(io.segs_ready), W'(1));
    offer(1, 3'd2, 1'b1, 32'h0000FFFF);
    @(negedge clk);
    chk("t1_lat_tvalid", W'(io.m_axis_tvalid), W'(1));
    chk("t1_b0_tuser", W'(io.m_axis_tuser), W'(mku(1)));
    @(negedge clk);
    chk("t1_b1_tlast", W'(io.m_axis_tlast), W'(1));
    chk("t1_b1_segs_ready", W'(io.segs_ready), W'(1));
    drain();
    h0 = hs_cnt;
    offer(2, 3'd3, 1'b1, 32'h00FFFFFF);
    offer(3, 3'd3, 1'b1, 32'h0000000F);
    repeat (3) @(negedge clk);
    #1;
    chk("t2_no_bubble", W'(hs_cnt - h0), W'(6));
    chk("t2_drop_cnt", W'(io.drop_cnt), '0);
    drain();
    h0 = hs_cnt;
    offer(4, 3'd4, 1'b0, 32'h00001234);
    bypass(4, 0, '1, 1'b0);
    bypass(4, 1, '1, 1'b0);
    bypass(4, 2, 32'h000000FF, 1'b1);
    drain();
    chk("t3_beats", W'(hs_cnt - h0), W'(7));
    chk("t3_idle_segs_ready", W'(io.segs_ready), W'(1));
    chk("t3_idle_s_tready", W'(io.s_axis_tready), '0);
    h0 = hs_cnt;
    rand_rdy = 1'b1;
    offer(5, 3'd4, 1'b1, 32'hF0F0F0F0);
    drain();
    rand_rdy = 1'b0;
    io.m_axis_tready = 1'b1;
    chk("t4_beats", W'(hs_cnt - h0), W'(4));
    offer(6, 3'd4, 1'b0, '1);
    drain();
    chk("t5_flush_segs_ready", W'(io.segs_ready), '0);
    repeat (3) pulse_drop();
    bypass(6, 0, 32'h0000FFFF, 1'b1);
    drain();
    chk("t5_drop_cnt", W'(io.drop_cnt), W'(3));
    h0 = hs_cnt;
    offer(7, 3'd0, 1'b1, 32'h00000003);
    offer(8, 3'd1, 1'b1, 32'h00000007);
    offer(9, 3'd3, 1'b0, 32'h0000001F);
    offer(10, 3'd5, 1'b1, 32'h000000FF);
    drain();
    chk("t5_clamp_beats", W'(hs_cnt - h0), W'(11));
    chk("t5_drop_hold", W'(io.drop_cnt), W'(3));
    offer(11, 3'd4, 1'b1, '1);
    @(posedge clk);
    @(posedge clk);
    #1 areset = 1'b1;
    @(negedge clk);
    chk("t6_beat2_data", io.m_axis_tdata, mk(11, 2));
    @(posedge clk);
    #1 q.delete();
    @(negedge clk);
    chk("t6_rst_tvalid", W'(io.m_axis_tvalid), '0);
    chk("t6_rst_segs_ready", W'(io.segs_ready), '0);
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("t6_rel_segs_ready", W'(io.segs_ready), W'(1));
    chk("t6_drop_cleared", W'(io.drop_cnt), '0);
    h0 = hs_cnt;
    offer(12, 3'd4, 1'b1, 32'h00000001);
    drain();
    chk("t6_fresh_beats", W'(hs_cnt - h0), W'(4));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
